// File: rtl/crc_arb_pkg.sv
// Shared types and constants for the CRC job arbiter.
// Holds FSM state codes, error codes and default widths.
package crc_arb_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_CRC_W       = 16;
  localparam int DEF_START_CYC   = 2;
  localparam int DEF_TIMEOUT_CYC = 65535;

  typedef logic [2:0] crc_arb_state_t;

  localparam crc_arb_state_t S_IDLE      = 3'd0;
  localparam crc_arb_state_t S_CHECK     = 3'd1;
  localparam crc_arb_state_t S_START     = 3'd2;
  localparam crc_arb_state_t S_WAIT_BUSY = 3'd3;
  localparam crc_arb_state_t S_WAIT_DONE = 3'd4;
  localparam crc_arb_state_t S_DONE      = 3'd5;

  typedef logic [1:0] crc_arb_err_t;

  localparam crc_arb_err_t ERR_NONE = 2'b00;
  localparam crc_arb_err_t ERR_LEN  = 2'b01;
  localparam crc_arb_err_t ERR_TMO  = 2'b10;

endpackage

// File: rtl/crc_job_arbiter_if.sv
// Engine-side bundle between the arbiter and the crc_system engine.
// master: arbiter (drives start/job), slave: engine (drives rdy/result).
interface crc_job_arbiter_if
  import crc_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CRC_W  = DEF_CRC_W
);
  logic              eng_start;
  logic [ADDR_W-1:0] eng_base;
  logic [ADDR_W:0]   eng_len;
  logic [CRC_W-1:0]  eng_target;
  logic              eng_rdy;
  logic              eng_ok;
  logic [CRC_W-1:0]  eng_crc;

  modport master (
    output eng_start, eng_base, eng_len, eng_target,
    input  eng_rdy, eng_ok, eng_crc
  );

  modport slave (
    input  eng_start, eng_base, eng_len, eng_target,
    output eng_rdy, eng_ok, eng_crc
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr.
// Ports: req, ptr in; one-hot gnt, its index idx, and valid out.
module rr_arbiter
  import crc_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int o = 0; o < N_REQ; o++) begin
      j = IW'((int'(ptr) + o) % N_REQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/crc_job_arbiter.sv
// Shares one CRC engine between N_REQ requesters with RR arbitration.
// Ports: clk50m/rst, packed per-requester jobs, grant/done/result, eng bus.
module crc_job_arbiter
  import crc_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CRC_W       = DEF_CRC_W,
  parameter int START_CYC   = DEF_START_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         clk50m,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ*ADDR_W-1:0]      base_i,
  input  logic [N_REQ*(ADDR_W+1)-1:0]  len_i,
  input  logic [N_REQ*CRC_W-1:0]       target_i,
  output logic [N_REQ-1:0]             gnt_o,
  output logic [N_REQ-1:0]             done_o,
  output logic [CRC_W-1:0]             crc_o,
  output logic                         ok_o,
  output logic [1:0]                   err_o,
  crc_job_arbiter_if.master            eng
);

  localparam int IW     = $clog2(N_REQ);
  localparam int LW     = ADDR_W + 1;
  localparam int WD_MAX =
    (TIMEOUT_CYC > START_CYC) ? TIMEOUT_CYC : START_CYC;
  localparam int WD_W   = $clog2(WD_MAX + 1);

  localparam logic [WD_W-1:0] START_LAST = WD_W'(START_CYC - 1);
  localparam logic [WD_W-1:0] TMO_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W+1:0] MEM_SZ   =
    (ADDR_W+2)'(1) << ADDR_W;

  logic [ADDR_W-1:0] base_a [N_REQ];
  logic [LW-1:0]     len_a  [N_REQ];
  logic [CRC_W-1:0]  tgt_a  [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign base_a[i] = base_i[i*ADDR_W +: ADDR_W];
    assign len_a[i]  = len_i[i*LW +: LW];
    assign tgt_a[i]  = target_i[i*CRC_W +: CRC_W];
  end

  crc_arb_state_t    state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LW-1:0]     len_q, len_d;
  logic [CRC_W-1:0]  tgt_q, tgt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ADDR_W-1:0] eb_q, eb_d;
  logic [LW-1:0]     el_q, el_d;
  logic [CRC_W-1:0]  et_q, et_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic              ok_q, ok_d;
  crc_arb_err_t      err_q, err_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // One extra bit so base + len cannot wrap before the compare.
  logic [ADDR_W+1:0] end_addr;
  logic              bad_job;

  assign end_addr = {2'b00, base_q} + {1'b0, len_q};
  assign bad_job  = (len_q == '0) || (end_addr > MEM_SZ);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    len_d   = len_q;
    tgt_d   = tgt_q;
    wd_d    = wd_q;
    eb_d    = eb_q;
    el_d    = el_q;
    et_d    = et_q;
    crc_d   = crc_q;
    ok_d    = ok_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          base_d  = base_a[arb_idx];
          len_d   = len_a[arb_idx];
          tgt_d   = tgt_a[arb_idx];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_job) begin
          crc_d   = '0;
          ok_d    = 1'b0;
          err_d   = ERR_LEN;
          state_d = S_DONE;
        end else begin
          eb_d    = base_q;
          el_d    = len_q;
          et_d    = tgt_q;
          wd_d    = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wd_q == START_LAST) begin
          wd_d    = '0;
          state_d = S_WAIT_BUSY;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (!eng.eng_rdy) begin
          wd_d    = '0;
          state_d = S_WAIT_DONE;
        end else if (wd_q == TMO_LAST) begin
          crc_d   = '0;
          ok_d    = 1'b0;
          err_d   = ERR_TMO;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (eng.eng_rdy) begin
          crc_d   = eng.eng_crc;
          ok_d    = eng.eng_ok;
          err_d   = ERR_NONE;
          state_d = S_DONE;
        end else if (wd_q == TMO_LAST) begin
          crc_d   = '0;
          ok_d    = 1'b0;
          err_d   = ERR_TMO;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(N_REQ - 1)) ?
                  '0 : idx_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      tgt_q   <= '0;
      wd_q    <= '0;
      eb_q    <= '0;
      el_q    <= '0;
      et_q    <= '0;
      crc_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      tgt_q   <= tgt_d;
      wd_q    <= wd_d;
      eb_q    <= eb_d;
      el_q    <= el_d;
      et_q    <= et_d;
      crc_q   <= crc_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = gnt_q & {N_REQ{state_q == S_DONE}};
  assign crc_o  = crc_q;
  assign ok_o   = ok_q;
  assign err_o  = err_q;

  assign eng.eng_start  = (state_q == S_START);
  assign eng.eng_base   = eb_q;
  assign eng.eng_len    = el_q;
  assign eng.eng_target = et_q;

endmodule
